// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param
// Transmit-only UART with an internal synchronous FIFO and in-block baud timing.
// Frame: one start bit (0), DATA_BITS payload bits LSB first, an optional
// even/odd parity bit, then STOP_BITS stop bits (1). Every bit lasts exactly
// BAUD_DIV clocks. Back-to-back frames leave no idle gap between them.
module uart_tx_fifo_param #(
    parameter int CLK_HZ     = 20000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        i_clk_mhz,
    input  logic                        i_rstn_mhz,
    output logic                        eo_uart_tx,
    input  logic [DATA_BITS-1:0]        i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic                        o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_tx_overflow
);

    localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int STOP_DIV = STOP_BITS * BAUD_DIV;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int DIV_W    = $clog2(STOP_DIV + 1);
    localparam int IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] BIT_LOAD   = DIV_W'(BAUD_DIV - 1);
    localparam logic [DIV_W-1:0] STOP_LOAD  = DIV_W'(STOP_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 overflow;

    // Transmit engine
    state_t               state;
    logic [DIV_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_line;

    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_end;
    logic shift;

    // Ready comes from the registered count only, so a pop on a full cycle
    // does not open the door for a write in that same cycle.
    assign o_tx_ready = (count != FULL_COUNT);
    assign push       = i_tx_valid && o_tx_ready;
    assign fifo_empty = (count == '0);
    assign bit_end    = (baud_cnt == '0);

    // Head is consumed when leaving IDLE or when a stop period ends with data
    // waiting; the latter chains the next start bit with no idle gap.
    assign pop   = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign shift = bit_end && ((state == S_START) || (state == S_DATA));

    assign eo_uart_tx    = tx_line;
    assign o_tx_busy     = (state != S_IDLE);
    assign o_fifo_count  = count;
    assign o_tx_overflow = overflow;

    // FIFO payload storage; data captured at write time only
    always_ff @(posedge i_clk_mhz) begin
        if (push) begin
            mem[wr_ptr] <= i_tx_data;
        end
    end

    // Frame payload: load on pop, shift right as each data bit is launched
    always_ff @(posedge i_clk_mhz) begin
        if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= (^mem[rd_ptr]) ^ ODD_PARITY;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    // FIFO pointers, occupancy and the registered overflow pulse
    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            overflow <= i_tx_valid && !o_tx_ready;
        end
    end

    // Frame sequencer; the line flop is loaded with the level of the state being entered
    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_line  <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        state    <= S_START;
                        tx_line  <= 1'b0;
                        bit_idx  <= '0;
                        baud_cnt <= BIT_LOAD;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        tx_line  <= shreg[0];
                        bit_idx  <= '0;
                        baud_cnt <= BIT_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY != 0) begin
                                state    <= S_PARITY;
                                tx_line  <= par_bit;
                                baud_cnt <= BIT_LOAD;
                            end else begin
                                state    <= S_STOP;
                                tx_line  <= 1'b1;
                                baud_cnt <= STOP_LOAD;
                            end
                        end else begin
                            bit_idx  <= bit_idx + IDX_W'(1);
                            tx_line  <= shreg[0];
                            baud_cnt <= BIT_LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - DIV_W'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        tx_line  <= 1'b1;
                        baud_cnt <= STOP_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state    <= S_START;
                            tx_line  <= 1'b0;
                            bit_idx  <= '0;
                            baud_cnt <= BIT_LOAD;
                        end else begin
                            state    <= S_IDLE;
                            tx_line  <= 1'b1;
                            baud_cnt <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - DIV_W'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    tx_line  <= 1'b1;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
